regbus_sched: RTL and testbench

REGBUS_SCHED -- requirements
Module: regbus_sched

---
 rtl/regbus_sched.sv | 156 +++++++++++++++
 tb/tb_regbus_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_sched.sv
// Two-requester round-robin scheduler in front of a simple active-low register bus.
// One access in flight at a time: IDLE arbitrates, ACCESS strobes, RDWAIT waits out read latency, DONE reports.
module regbus_sched #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [4:0]  a_addr,
   input  logic        a_wide,
   input  logic [63:0] a_wdata,
   output logic        a_done,
   output logic        a_err,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [4:0]  b_addr,
   input  logic        b_wide,
   input  logic [63:0] b_wdata,
   output logic        b_done,
   output logic        b_err,
   output logic [31:0] rdata,
   output logic        g_wrb,
   output logic        g_rdb,
   output logic [4:0]  g_dout_w0x0f,
   output logic [63:0] din,
   output logic        n9_bit_write,
   input  logic [31:0] g_dout,
   output logic        busy
);

   // Handshake: a requester holds req (and its command fields) high until it sees
   // its one-cycle done; commands are sampled only while the scheduler is IDLE.

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);
   localparam logic       OWN_A    = 1'b0;
   localparam logic       OWN_B    = 1'b1;

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic        wide_q, wide_d;
   logic        err_q, err_d;
   logic [4:0]  addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;

   logic        grant_b;
   logic [4:0]  sel_addr;
   logic        wr_strobe;
   logic        rd_strobe;

   // On a tie the requester that was not granted last wins.
   assign grant_b  = b_req && (!a_req || (last_q == OWN_A));
   assign sel_addr = grant_b ? b_addr : a_addr;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      we_d    = we_q;
      wide_d  = wide_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               owner_d = grant_b;
               last_d  = grant_b;
               we_d    = grant_b ? b_we    : a_we;
               wide_d  = grant_b ? b_wide  : a_wide;
               wdata_d = grant_b ? b_wdata : a_wdata;
               addr_d  = sel_addr;
               err_d   = (sel_addr[4:3] == 2'b11);
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (err_q || we_q) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = S_RDWAIT;
            end
         end
         S_RDWAIT: begin
            if (cnt_q == 3'd0) begin
               rdata_d = g_dout;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= OWN_B;
         owner_q <= OWN_A;
         we_q    <= 1'b0;
         wide_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 5'd0;
         wdata_q <= 64'd0;
         cnt_q   <= 3'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         wide_q  <= wide_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Illegal addresses never reach the bus; the read strobe spans ACCESS and all of RDWAIT.
   assign wr_strobe = (state_q == S_ACCESS) && we_q && !err_q;
   assign rd_strobe = ((state_q == S_ACCESS) && !we_q && !err_q) || (state_q == S_RDWAIT);

   assign g_wrb        = !wr_strobe;
   assign g_rdb        = !rd_strobe;
   assign g_dout_w0x0f = (wr_strobe || rd_strobe) ? addr_q : 5'd0;
   assign din          = wr_strobe ? wdata_q : 64'd0;
   assign n9_bit_write = wr_strobe && wide_q;

   assign a_done = (state_q == S_DONE) && (owner_q == OWN_A);
   assign b_done = (state_q == S_DONE) && (owner_q == OWN_B);
   assign a_err  = a_done && err_q;
   assign b_err  = b_done && err_q;
   assign rdata  = rdata_q;
   assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_regbus_sched.sv
// Directed bench for regbus_sched with RD_LAT=2. Cycle numbering: the cycle in which
// req is first presented is cycle 1, so a write's done lands in cycle 3 and a read's in RD_LAT+3.
module tb_regbus_sched;

   localparam int unsigned RD_LAT = 2;
   localparam int          MAX_CYC = 40;

   logic        sysclk = 1'b0;
   logic        reset;
   logic        a_req, a_we, a_wide;
   logic [4:0]  a_addr;
   logic [63:0] a_wdata;
   logic        a_done, a_err;
   logic        b_req, b_we, b_wide;
   logic [4:0]  b_addr;
   logic [63:0] b_wdata;
   logic        b_done, b_err;
   logic [31:0] rdata;
   logic        g_wrb, g_rdb;
   logic [4:0]  g_dout_w0x0f;
   logic [63:0] din;
   logic        n9_bit_write;
   logic [31:0] g_dout;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic       exp_q[$];
   int         exp_cyc_q[$];

   regbus_sched #(.RD_LAT(RD_LAT)) dut (
      .sysclk(sysclk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wide(a_wide), .a_wdata(a_wdata),
      .a_done(a_done), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wide(b_wide), .b_wdata(b_wdata),
      .b_done(b_done), .b_err(b_err),
      .rdata(rdata), .g_wrb(g_wrb), .g_rdb(g_rdb), .g_dout_w0x0f(g_dout_w0x0f),
      .din(din), .n9_bit_write(n9_bit_write), .g_dout(g_dout), .busy(busy)
   );

   // clock / reset
   always #5 sysclk = ~sysclk;

   // Drives one access from a single requester and records what the bus did until its done.
   task automatic run_access(input bit is_b, input bit we, input logic [4:0] addr,
                             input bit wide, input logic [63:0] wdata,
                             output int done_cyc, output int wrb_cyc, output int rdb_cyc,
                             output logic [4:0] s_addr, output logic [63:0] s_din,
                             output logic s_n9, output logic err, output logic [31:0] rd,
                             output bit overlap);
      done_cyc = -1; wrb_cyc = 0; rdb_cyc = 0; s_addr = '0; s_din = '0;
      s_n9 = 1'b0; err = 1'bx; rd = 'x; overlap = 1'b0;
      @(negedge sysclk);
      if (is_b) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wide = wide; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wide = wide; a_wdata = wdata;
      end
      for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
         if (!g_wrb) begin
            wrb_cyc++; s_addr = g_dout_w0x0f; s_din = din; s_n9 = n9_bit_write;
         end
         if (!g_rdb) begin
            rdb_cyc++; s_addr = g_dout_w0x0f;
         end
         if (!g_wrb && !g_rdb) overlap = 1'b1;
         if (is_b ? b_done : a_done) begin
            done_cyc = cyc;
            err = is_b ? b_err : a_err;
            rd = rdata;
            break;
         end
         @(negedge sysclk);
      end
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wide = 0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wide = 0; b_wdata = '0;
      g_dout = '0;
      repeat (3) @(negedge sysclk);
      total++;
      if ({g_wrb, g_rdb} !== 2'b11) begin
         bad++; $display("FAIL reset_strobes got=%b exp=11", {g_wrb, g_rdb});
      end
      total++;
      if ({g_dout_w0x0f, din, n9_bit_write} !== '0) begin
         bad++; $display("FAIL reset_bus addr=%h din=%h n9=%b exp=0", g_dout_w0x0f, din, n9_bit_write);
      end
      total++;
      if ({a_done, b_done, a_err, b_err, busy} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000", {a_done, b_done, a_err, b_err, busy});
      end
      total++;
      if (rdata !== 32'd0) begin
         bad++; $display("FAIL reset_rdata got=%h exp=0", rdata);
      end
      reset = 1'b0;
   endtask

   task automatic test_write();
      int dc, wc, rc; logic [4:0] sa; logic [63:0] sd; logic n9, er; logic [31:0] rd; bit ov;
      run_access(1'b0, 1'b1, 5'h0A, 1'b0, {32'h0, 32'h1234_5678}, dc, wc, rc, sa, sd, n9, er, rd, ov);
      total++;
      if (dc !== 3) begin bad++; $display("FAIL write_done_cycle got=%0d exp=3", dc); end
      total++;
      if (wc !== 1 || rc !== 0) begin
         bad++; $display("FAIL write_strobe_cycles wrb=%0d rdb=%0d exp=1,0", wc, rc);
      end
      total++;
      if (sa !== 5'h0A || sd[31:0] !== 32'h1234_5678 || n9 !== 1'b0) begin
         bad++; $display("FAIL write_bus addr=%h din=%h n9=%b exp=0a,12345678,0", sa, sd[31:0], n9);
      end
      total++;
      if (er !== 1'b0) begin bad++; $display("FAIL write_err got=%b exp=0", er); end
   endtask

   task automatic test_read();
      int dc, wc, rc; logic [4:0] sa; logic [63:0] sd; logic n9, er; logic [31:0] rd; bit ov;
      g_dout = 32'hFFFF_0001;
      run_access(1'b1, 1'b0, 5'h11, 1'b0, '0, dc, wc, rc, sa, sd, n9, er, rd, ov);
      total++;
      if (dc !== 5) begin bad++; $display("FAIL read_done_cycle got=%0d exp=5", dc); end
      total++;
      if (rc !== 3 || wc !== 0) begin
         bad++; $display("FAIL read_strobe_cycles rdb=%0d wrb=%0d exp=3,0", rc, wc);
      end
      total++;
      if (rd !== 32'hFFFF_0001 || sa !== 5'h11 || er !== 1'b0) begin
         bad++; $display("FAIL read_data rdata=%h addr=%h err=%b exp=ffff0001,11,0", rd, sa, er);
      end
      g_dout = 32'h5555_AAAA;
   endtask

   task automatic test_illegal();
      int dc, wc, rc; logic [4:0] sa; logic [63:0] sd; logic n9, er; logic [31:0] rd; bit ov;
      run_access(1'b0, 1'b1, 5'h1C, 1'b0, 64'h1, dc, wc, rc, sa, sd, n9, er, rd, ov);
      total++;
      if (dc !== 3 || er !== 1'b1) begin
         bad++; $display("FAIL illegal_write done=%0d err=%b exp=3,1", dc, er);
      end
      total++;
      if (wc !== 0 || rc !== 0) begin
         bad++; $display("FAIL illegal_write_strobe wrb=%0d rdb=%0d exp=0,0", wc, rc);
      end
      run_access(1'b1, 1'b0, 5'h18, 1'b0, '0, dc, wc, rc, sa, sd, n9, er, rd, ov);
      total++;
      if (dc !== 3 || er !== 1'b1 || rc !== 0 || rd !== 32'hFFFF_0001) begin
         bad++; $display("FAIL illegal_read done=%0d err=%b rdb=%0d rdata=%h exp=3,1,0,ffff0001", dc, er, rc, rd);
      end
   endtask

   task automatic test_wide();
      int dc, wc, rc; logic [4:0] sa; logic [63:0] sd; logic n9, er; logic [31:0] rd; bit ov;
      run_access(1'b0, 1'b1, 5'h03, 1'b1, 64'hDEAD_BEEF_0000_0001, dc, wc, rc, sa, sd, n9, er, rd, ov);
      total++;
      if (wc !== 1 || n9 !== 1'b1 || sd !== 64'hDEAD_BEEF_0000_0001) begin
         bad++; $display("FAIL wide_write wrb=%0d n9=%b din=%h exp=1,1,deadbeef00000001", wc, n9, sd);
      end
      total++;
      if (rdata !== 32'hFFFF_0001) begin
         bad++; $display("FAIL rdata_hold got=%h exp=ffff0001", rdata);
      end
   endtask

   task automatic test_req_drop();
      @(negedge sysclk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'h07; a_wide = 1'b0; a_wdata = 64'h77;
      @(negedge sysclk);
      total++;
      if (g_wrb !== 1'b0 || g_dout_w0x0f !== 5'h07) begin
         bad++; $display("FAIL drop_access wrb=%b addr=%h exp=0,07", g_wrb, g_dout_w0x0f);
      end
      a_req = 1'b0; a_addr = 5'h02; a_we = 1'b0;
      @(negedge sysclk);
      total++;
      if (a_done !== 1'b1 || a_err !== 1'b0) begin
         bad++; $display("FAIL drop_done done=%b err=%b exp=1,0", a_done, a_err);
      end
   endtask

   task automatic test_back_to_back();
      int dones;
      reset = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
      exp_cyc_q = {3, 6, 9, 12};
      a_req = 1; a_we = 1; a_addr = 5'h01; a_wide = 0; a_wdata = 64'hA;
      b_req = 1; b_we = 1; b_addr = 5'h02; b_wide = 0; b_wdata = 64'hB;
      dones = 0;
      for (int cyc = 1; cyc <= MAX_CYC && dones < 4; cyc++) begin
         if (!g_wrb && !g_rdb) begin
            total++; bad++; $display("FAIL rr_overlap cycle=%0d", cyc);
         end
         if (a_done && b_done) begin
            total++; bad++; $display("FAIL rr_double_done cycle=%0d", cyc);
         end
         if (a_done || b_done) begin
            logic who; int want_cyc;
            who = exp_q.pop_front();
            want_cyc = exp_cyc_q.pop_front();
            total++;
            if (b_done !== who || cyc !== want_cyc) begin
               bad++; $display("FAIL rr_order got=%s@%0d exp=%s@%0d", b_done ? "B" : "A", cyc,
                               who ? "B" : "A", want_cyc);
            end
            dones++;
         end
         @(negedge sysclk);
      end
      total++;
      if (dones !== 4) begin bad++; $display("FAIL rr_timeout dones=%0d exp=4", dones); end
      a_req = 0; b_req = 0;
      // A alone, held: the DONE cycle cannot re-grant, so the next done is 3 cycles later.
      @(negedge sysclk);
      @(negedge sysclk);
      a_req = 1;
      dones = 0;
      for (int cyc = 1; cyc <= MAX_CYC && dones < 2; cyc++) begin
         if (a_done) begin
            dones++;
            total++;
            if (cyc !== 3 * dones) begin
               bad++; $display("FAIL solo_regrant got=%0d exp=%0d", cyc, 3 * dones);
            end
         end
         @(negedge sysclk);
      end
      a_req = 0;
      total++;
      if (dones !== 2) begin bad++; $display("FAIL solo_timeout dones=%0d exp=2", dones); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge sysclk);
      g_dout = 32'hABCD_0123;
      a_req = 1; a_we = 0; a_addr = 5'h05; a_wide = 0;
      @(negedge sysclk);
      @(negedge sysclk);
      total++;
      if (g_rdb !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL mid_rdwait rdb=%b busy=%b exp=0,1", g_rdb, busy);
      end
      reset = 1'b1;
      @(negedge sysclk);
      total++;
      if (g_rdb !== 1'b1 || busy !== 1'b0 || a_done !== 1'b0 || rdata !== 32'd0) begin
         bad++; $display("FAIL mid_reset rdb=%b busy=%b done=%b rdata=%h exp=1,0,0,0",
                         g_rdb, busy, a_done, rdata);
      end
      reset = 1'b0; a_req = 0;
      seen = 0;
      repeat (6) begin
         @(negedge sysclk);
         if (a_done || b_done) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_illegal();
      test_wide();
      test_req_drop();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
